// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with holding FIFO
//
// Ports:
//   br       : clock, rising edge
//   rst      : asynchronous active-high reset
//   wr_en    : write strobe for wr_data, accepted when full=0
//   wr_data  : character to transmit (DATA_W bits)
//   par_en   : parity bit enable
//   par_odd  : 1 = odd parity, 0 = even parity
//   stop2    : 1 = two stop bits, 0 = one
//   tx       : registered serial output, idles high
//   busy     : a frame is in progress
//   full     : FIFO occupancy equals FIFO_DEPTH
//   count    : FIFO occupancy
//   done     : one-cycle pulse after the last stop bit of a frame
//   ovf      : sticky, set by a write while full
module uart_tx_param #(
   parameter int DATA_W       = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic                          br,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [DATA_W-1:0]             wr_data,
   input  logic                          par_en,
   input  logic                          par_odd,
   input  logic                          stop2,
   output logic                          tx,
   output logic                          busy,
   output logic                          full,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          done,
   output logic                          ovf
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   // A single-cycle bit period still needs a 1-bit counter to stay legal.
   localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW  = $clog2(DATA_W);

   localparam logic [BCW-1:0] BIT_LAST = BCW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0]  IDX_LAST = IW'(DATA_W - 1);
   localparam logic [CW-1:0]  DEPTH    = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP1, STOP2
   } state_t;

   state_t state, state_next;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic              push, pop;
   logic [CW-1:0]     count_next;
   logic [DATA_W-1:0] head;

   logic [BCW-1:0]    bit_cnt;
   logic              bit_end;
   logic [IW-1:0]     bit_idx;
   logic [DATA_W-1:0] shift, shift_next;
   logic              par_bit, par_en_q, stop2_q;
   logic              tx_next, done_next, frame_end;

   assign push    = wr_en && !full;
   assign head    = mem[rd_ptr];
   assign bit_end = (bit_cnt == BIT_LAST);
   assign busy    = (state != IDLE);

   // Holding FIFO
   always_ff @(posedge br) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_comb begin
      count_next = count + CW'(push) - CW'(pop);
   end

   always_ff @(posedge br or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next;
         full  <= (count_next == DEPTH);
         // A write while full is dropped even if a pop frees a slot this edge.
         if (wr_en && full) begin
            ovf <= 1'b1;
         end
      end
   end

   // Frame sequencer: next state, pop request and next tx level
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      done_next  = 1'b0;
      frame_end  = 1'b0;
      shift_next = shift;
      tx_next    = 1'b1;

      case (state)
         IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               state_next = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_next = DATA;
            end
         end
         DATA: begin
            if (bit_end && (bit_idx == IDX_LAST)) begin
               state_next = par_en_q ? PARITY : STOP1;
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_next = STOP1;
            end
         end
         STOP1: begin
            if (bit_end) begin
               if (stop2_q) begin
                  state_next = STOP2;
               end else begin
                  frame_end = 1'b1;
               end
            end
         end
         STOP2: begin
            if (bit_end) begin
               frame_end = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // Back-to-back: the next start bit begins on the edge that ends this frame.
      if (frame_end) begin
         done_next = 1'b1;
         if (count != '0) begin
            pop        = 1'b1;
            state_next = START;
         end else begin
            state_next = IDLE;
         end
      end

      if (pop) begin
         shift_next = head;
      end else if ((state == DATA) && bit_end) begin
         shift_next = shift >> 1;
      end

      // tx is registered, so it takes the level of the state being entered.
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         PARITY:  tx_next = par_bit;
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge br or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
         tx       <= 1'b1;
         done     <= 1'b0;
      end else begin
         state <= state_next;
         tx    <= tx_next;
         done  <= done_next;
         shift <= shift_next;

         if ((state == IDLE) || bit_end) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + BCW'(1);
         end

         if (state != DATA) begin
            bit_idx <= '0;
         end else if (bit_end) begin
            bit_idx <= bit_idx + IW'(1);
         end

         // Frame configuration is captured at pop and held for the whole frame.
         if (pop) begin
            par_en_q <= par_en;
            stop2_q  <= stop2;
            par_bit  <= (^head) ^ par_odd;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed self-checking bench for uart_tx_param
module tb_uart_tx_param;

   logic br, rst, par_en, par_odd, stop2;

   logic       wr_en_a, tx_a, busy_a, full_a, done_a, ovf_a;
   logic [7:0] wr_data_a;
   logic [2:0] count_a;

   logic       wr_en_b, tx_b, busy_b, full_b, done_b, ovf_b;
   logic [7:0] wr_data_b;
   logic [2:0] count_b;

   logic       wr_en_c, tx_c, busy_c, full_c, done_c, ovf_c;
   logic [4:0] wr_data_c;
   logic [2:0] count_c;

   int checks = 0;
   int errors = 0;

   uart_tx_param #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(1)) dut_a (
      .br(br), .rst(rst), .wr_en(wr_en_a), .wr_data(wr_data_a),
      .par_en(par_en), .par_odd(par_odd), .stop2(stop2),
      .tx(tx_a), .busy(busy_a), .full(full_a), .count(count_a),
      .done(done_a), .ovf(ovf_a)
   );

   uart_tx_param #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4)) dut_b (
      .br(br), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b),
      .par_en(par_en), .par_odd(par_odd), .stop2(stop2),
      .tx(tx_b), .busy(busy_b), .full(full_b), .count(count_b),
      .done(done_b), .ovf(ovf_b)
   );

   uart_tx_param #(.DATA_W(5), .FIFO_DEPTH(4), .CLKS_PER_BIT(1)) dut_c (
      .br(br), .rst(rst), .wr_en(wr_en_c), .wr_data(wr_data_c),
      .par_en(par_en), .par_odd(par_odd), .stop2(stop2),
      .tx(tx_c), .busy(busy_c), .full(full_c), .count(count_c),
      .done(done_c), .ovf(ovf_c)
   );

   initial begin
      br = 1'b0;
      forever #5 br = ~br;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [63:0] got, exp;
   logic [10:0] e11;
   logic [7:0]  w [6];
   int          dcnt, bcnt, lows;

   initial begin
      rst       = 1'b1;
      par_en    = 1'b0;
      par_odd   = 1'b0;
      stop2     = 1'b0;
      wr_en_a   = 1'b0; wr_data_a = '0;
      wr_en_b   = 1'b0; wr_data_b = '0;
      wr_en_c   = 1'b0; wr_data_c = '0;
      repeat (2) @(negedge br);

      // Reset state {tx,busy,full,count,done,ovf}
      check("reset_a", 64'({tx_a, busy_a, full_a, count_a, done_a, ovf_a}), 64'h80);
      check("reset_b", 64'({tx_b, busy_b, full_b, count_b, done_b, ovf_b}), 64'h80);
      check("reset_c", 64'({tx_c, busy_c, full_c, count_c, done_c, ovf_c}), 64'h80);
      rst = 1'b0;
      @(negedge br);

      // 0xA5, even parity, one stop bit
      par_en = 1'b1; par_odd = 1'b0; stop2 = 1'b0;
      wr_en_a = 1'b1; wr_data_a = 8'hA5;
      @(negedge br);
      wr_en_a = 1'b0;
      check("a5_count_after_write", 64'(count_a), 64'd1);
      check("a5_idle_before_pop", 64'({tx_a, busy_a}), 64'b10);
      @(negedge br);
      got = '0; dcnt = 0;
      for (int i = 0; i < 11; i++) begin
         got[i] = tx_a;
         dcnt = dcnt + int'(done_a);
         @(negedge br);
      end
      check("a5_frame", got, 64'h54A);
      check("a5_no_early_done", 64'(dcnt), 64'd0);
      check("a5_done_end", 64'({done_a, tx_a, busy_a}), 64'b110);
      @(negedge br);
      check("a5_done_single", 64'(done_a), 64'd0);

      // 0x07 odd parity then even parity, back-to-back
      par_odd = 1'b1;
      wr_en_a = 1'b1; wr_data_a = 8'h07;
      @(negedge br);
      @(negedge br);
      wr_en_a = 1'b0;
      par_odd = 1'b0;
      got = '0; dcnt = 0; bcnt = 0;
      for (int i = 0; i < 22; i++) begin
         got[i] = tx_a;
         dcnt = dcnt + int'(done_a);
         bcnt = bcnt + int'(!busy_a);
         @(negedge br);
      end
      check("p07_frames", got, 64'({11'h60E, 11'h40E}));
      check("p07_mid_done", 64'(dcnt), 64'd1);
      check("p07_busy_held", 64'(bcnt), 64'd0);
      check("p07_end", 64'({done_a, busy_a}), 64'b10);
      @(negedge br);

      // Six consecutive writes: five accepted, sixth overflows
      par_en = 1'b0; stop2 = 1'b0;
      w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33;
      w[3] = 8'h44; w[4] = 8'h55; w[5] = 8'h66;
      got = '0; dcnt = 0;
      for (int j = 0; j < 6; j++) begin
         if (j == 5) begin
            check("fill_state", 64'({count_a, full_a, ovf_a}), 64'b100_1_0);
         end
         if (j >= 2) begin
            got[j-2] = tx_a;
         end
         wr_en_a = 1'b1; wr_data_a = w[j];
         @(negedge br);
      end
      wr_en_a = 1'b0;
      check("ovf_state", 64'({count_a, full_a, ovf_a}), 64'b100_1_1);
      for (int s = 4; s < 50; s++) begin
         got[s] = tx_a;
         dcnt = dcnt + int'(done_a);
         @(negedge br);
      end
      exp = '0;
      for (int j = 0; j < 5; j++) begin
         exp[j*10 +: 10] = {1'b1, w[j], 1'b0};
      end
      check("fifo_frames", got, exp);
      check("fifo_done_count", 64'(dcnt), 64'd4);
      check("fifo_end", 64'({done_a, busy_a, count_a, ovf_a}), 64'b1_0_000_1);

      // Reset mid-DATA with two entries queued
      @(negedge br);
      for (int j = 0; j < 3; j++) begin
         wr_en_a = 1'b1; wr_data_a = 8'h00;
         @(negedge br);
      end
      wr_en_a = 1'b0;
      check("rst_queued", 64'(count_a), 64'd2);
      @(negedge br);
      check("rst_pre_data_bit", 64'({tx_a, busy_a}), 64'b01);
      rst = 1'b1;
      #1;
      check("rst_async", 64'({tx_a, busy_a, full_a, count_a, done_a, ovf_a}), 64'h80);
      @(negedge br);
      rst = 1'b0;
      lows = 0; bcnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge br);
         lows = lows + int'(!tx_a);
         bcnt = bcnt + int'(busy_a);
      end
      check("rst_no_frames", 64'({lows[7:0], bcnt[7:0]}), 64'h0);

      // 0x3C, CLKS_PER_BIT=4, no parity, two stop bits
      par_en = 1'b0; stop2 = 1'b1;
      wr_en_b = 1'b1; wr_data_b = 8'h3C;
      @(negedge br);
      wr_en_b = 1'b0;
      @(negedge br);
      got = '0; dcnt = 0;
      for (int i = 0; i < 44; i++) begin
         got[i] = tx_b;
         dcnt = dcnt + int'(done_b);
         @(negedge br);
      end
      e11 = 11'h678;
      exp = '0;
      for (int i = 0; i < 44; i++) begin
         exp[i] = e11[i/4];
      end
      check("cpb4_frame", got, exp);
      check("cpb4_no_early_done", 64'(dcnt), 64'd0);
      check("cpb4_end", 64'({done_b, busy_b, tx_b}), 64'b101);

      // DATA_W=5, 0x1F, even parity, one stop bit
      par_en = 1'b1; par_odd = 1'b0; stop2 = 1'b0;
      wr_en_c = 1'b1; wr_data_c = 5'h1F;
      @(negedge br);
      wr_en_c = 1'b0;
      @(negedge br);
      got = '0;
      for (int i = 0; i < 8; i++) begin
         got[i] = tx_c;
         @(negedge br);
      end
      check("w5_frame", got, 64'hFE);
      check("w5_end", 64'({done_c, busy_c, tx_c}), 64'b101);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
